// File: rtl/bsg_fakeram_arb_pkg.sv
// Shared constants and FSM state type for the 1024x32 fake-RAM arbiter.
package bsg_fakeram_arb_pkg;

  localparam int unsigned ELS_C        = 1024;
  localparam int unsigned WIDTH_C      = 32;
  localparam int unsigned ADDR_WIDTH_C = 10;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_arb_rr_2.sv
// Two-way round-robin arbiter; the last-grant register moves only on adv_i.
module bsg_arb_rr_2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  // With both requesting, the port that did not win last time goes first.
  always_comb begin
    grant_o = 2'b00;
    last_d  = last_q;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    if (adv_i && (grant_o != 2'b00)) begin
      last_d = grant_o[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bsg_fakeram_1024x32_arb_ctrl.sv
// Zero-fills a 1024x32 SRAM after reset, then arbitrates two request ports
// onto it and buffers one read response per port.
module bsg_fakeram_1024x32_arb_ctrl
  import bsg_fakeram_arb_pkg::*;
#(
  parameter int unsigned els_p        = ELS_C,
  parameter int unsigned width_p      = WIDTH_C,
  parameter int unsigned addr_width_p = ADDR_WIDTH_C
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  output logic                         init_done_o,
  input  logic [1:0]                   v_i,
  output logic [1:0]                   ready_o,
  input  logic [1:0]                   w_i,
  input  logic [1:0][addr_width_p-1:0] addr_i,
  input  logic [1:0][width_p-1:0]      data_i,
  input  logic [1:0][width_p-1:0]      mask_i,
  output logic [1:0]                   v_o,
  output logic [1:0][width_p-1:0]      data_o,
  input  logic [1:0]                   yumi_i,
  output logic                         sram_ce_o,
  output logic                         sram_we_o,
  output logic [addr_width_p-1:0]      sram_addr_o,
  output logic [width_p-1:0]           sram_wd_o,
  output logic [width_p-1:0]           sram_w_mask_o,
  input  logic [width_p-1:0]           sram_rd_i
);

  localparam logic [addr_width_p-1:0] LAST_ADDR = addr_width_p'(els_p - 1);

  state_e                    state_q, state_d;
  logic [addr_width_p-1:0]   cnt_q, cnt_d;
  logic [1:0]                inflight_q, inflight_d;
  logic [1:0]                v_q, v_d;
  logic [1:0][width_p-1:0]   data_q, data_d;
  logic [1:0]                elig_c;
  logic [1:0]                grant_c;
  logic                      gidx_c;

  // A read may only be taken when its response slot is free or being freed now.
  always_comb begin
    elig_c = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig_c[i] = v_i[i] && !reset_i && (state_q == RUN) &&
                  (w_i[i] || (!inflight_q[i] && (!v_q[i] || yumi_i[i])));
    end
  end

  bsg_arb_rr_2 u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (elig_c),
    .adv_i   (1'b1),
    .grant_o (grant_c)
  );

  assign gidx_c      = grant_c[1];
  assign ready_o     = grant_c;
  assign v_o         = v_q;
  assign data_o      = data_q;
  assign init_done_o = (state_q == RUN);

  // Next state and SRAM port drive.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sram_ce_o     = 1'b0;
    sram_we_o     = 1'b0;
    sram_addr_o   = '0;
    sram_wd_o     = '0;
    sram_w_mask_o = '0;
    if (!reset_i) begin
      unique case (state_q)
        INIT: begin
          sram_ce_o     = 1'b1;
          sram_we_o     = 1'b1;
          sram_addr_o   = cnt_q;
          sram_w_mask_o = '1;
          cnt_d         = cnt_q + addr_width_p'(1);
          if (cnt_q == LAST_ADDR) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (grant_c != 2'b00) begin
            sram_ce_o     = 1'b1;
            sram_we_o     = w_i[gidx_c];
            sram_addr_o   = addr_i[gidx_c];
            sram_wd_o     = data_i[gidx_c];
            sram_w_mask_o = mask_i[gidx_c];
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  // Response buffers: a landing read overrides a same-cycle consume.
  always_comb begin
    inflight_d = grant_c & ~w_i;
    v_d        = v_q;
    data_d     = data_q;
    for (int i = 0; i < 2; i++) begin
      if (v_q[i] && yumi_i[i]) begin
        v_d[i] = 1'b0;
      end
      if (inflight_q[i]) begin
        v_d[i]    = 1'b1;
        data_d[i] = sram_rd_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      inflight_q <= 2'b00;
      v_q        <= 2'b00;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      v_q        <= v_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_bsg_fakeram_1024x32_arb_ctrl.sv
// Bench: fake SRAM behind the controller, directed scenarios, then a
// randomized run checked against a per-port response model.
module tb_bsg_fakeram_1024x32_arb_ctrl;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              init_done_o;
  logic [1:0]        v_i, ready_o, w_i, v_o, yumi_i;
  logic [1:0][9:0]   addr_i;
  logic [1:0][31:0]  data_i, mask_i, data_o;
  logic              sram_ce_o, sram_we_o;
  logic [9:0]        sram_addr_o;
  logic [31:0]       sram_wd_o, sram_w_mask_o, sram_rd_i;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fake_mem [1024];
  logic [31:0] ref_mem  [1024];

  always #5 clk = ~clk;

  bsg_fakeram_1024x32_arb_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .init_done_o   (init_done_o),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .w_i           (w_i),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .mask_i        (mask_i),
    .v_o           (v_o),
    .data_o        (data_o),
    .yumi_i        (yumi_i),
    .sram_ce_o     (sram_ce_o),
    .sram_we_o     (sram_we_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wd_o     (sram_wd_o),
    .sram_w_mask_o (sram_w_mask_o),
    .sram_rd_i     (sram_rd_i)
  );

  // Synchronous SRAM: masked write, read data one cycle later.
  always @(posedge clk) begin
    if (sram_ce_o) begin
      if (sram_we_o)
        fake_mem[sram_addr_o] <= (fake_mem[sram_addr_o] & ~sram_w_mask_o) | (sram_wd_o & sram_w_mask_o);
      else
        sram_rd_i <= fake_mem[sram_addr_o];
    end
  end

  task automatic idle_inputs();
    v_i = 2'b00; w_i = 2'b00; yumi_i = 2'b00;
    addr_i = '0; data_i = '0; mask_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_i = 1'b1; idle_inputs();
    @(negedge clk);
    @(negedge clk); reset_i = 1'b0;
    #1;
  endtask

  // Follows the zero-fill, checking each write, and returns cycles until init_done_o.
  task automatic wait_init(output int n);
    n = 0;
    while (init_done_o !== 1'b1 && n < 1100) begin
      n_vec++;
      if (sram_ce_o !== 1'b1 || sram_we_o !== 1'b1 || sram_addr_o !== 10'(n) ||
          sram_wd_o !== 32'h0 || sram_w_mask_o !== 32'hFFFF_FFFF || ready_o !== 2'b00) begin
        n_err++;
        $display("FAIL init_fill cyc=%0d ce=%b we=%b addr=%0d wd=%h mask=%h ready=%b (want 1 1 %0d 0 ffffffff 00)",
                 n, sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o, sram_w_mask_o, ready_o, n);
      end
      @(negedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset_i = 1'b1; idle_inputs(); v_i = 2'b11;
    #1;
    n_vec++;
    if (sram_ce_o !== 1'b0 || sram_we_o !== 1'b0 || sram_addr_o !== 10'd0 ||
        sram_wd_o !== 32'h0 || sram_w_mask_o !== 32'h0 || ready_o !== 2'b00) begin
      n_err++;
      $display("FAIL reset_sram ce=%b we=%b addr=%0d ready=%b (want all 0)", sram_ce_o, sram_we_o, sram_addr_o, ready_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (v_o !== 2'b00 || data_o !== '0 || init_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state v_o=%b data_o=%h init_done=%b (want 00 0 0)", v_o, data_o, init_done_o);
    end
  endtask

  task automatic test_init();
    int n;
    @(negedge clk); reset_i = 1'b0; #1;
    wait_init(n);
    v_i = 2'b00;
    n_vec++;
    if (n != 1024) begin
      n_err++; $display("FAIL init_latency got %0d cycles want 1024", n);
    end
    @(negedge clk); v_i = 2'b01; w_i = 2'b00; addr_i[0] = 10'd513; #1;
    n_vec++;
    if (ready_o !== 2'b01 || sram_ce_o !== 1'b1 || sram_we_o !== 1'b0 || sram_addr_o !== 10'd513) begin
      n_err++; $display("FAIL read513_issue ready=%b ce=%b we=%b addr=%0d (want 01 1 0 513)", ready_o, sram_ce_o, sram_we_o, sram_addr_o);
    end
    @(negedge clk); v_i = 2'b00; #1;
    @(negedge clk); #1;
    n_vec++;
    if (v_o !== 2'b01 || data_o[0] !== 32'h0) begin
      n_err++; $display("FAIL read513_data v_o=%b data=%h (want 01 00000000)", v_o, data_o[0]);
    end
    yumi_i = 2'b01;
    @(negedge clk); yumi_i = 2'b00; #1;
  endtask

  task automatic test_masked_write();
    @(negedge clk); v_i = 2'b01; w_i = 2'b01; addr_i[0] = 10'd5;
    data_i[0] = 32'hDEAD_BEEF; mask_i[0] = 32'hFFFF_0000; #1;
    n_vec++;
    if (ready_o !== 2'b01 || sram_we_o !== 1'b1 || sram_wd_o !== 32'hDEAD_BEEF || sram_w_mask_o !== 32'hFFFF_0000) begin
      n_err++; $display("FAIL mwrite_issue ready=%b we=%b wd=%h mask=%h", ready_o, sram_we_o, sram_wd_o, sram_w_mask_o);
    end
    @(negedge clk); w_i = 2'b00; #1;
    n_vec++;
    if (ready_o !== 2'b01 || sram_ce_o !== 1'b1 || sram_we_o !== 1'b0) begin
      n_err++; $display("FAIL mread_issue ready=%b ce=%b we=%b (want 01 1 0)", ready_o, sram_ce_o, sram_we_o);
    end
    @(negedge clk); v_i = 2'b00; #1;
    n_vec++;
    if (v_o !== 2'b00) begin
      n_err++; $display("FAIL mread_early v_o=%b want 00 one cycle after accept", v_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (v_o !== 2'b01 || data_o[0] !== 32'hDEAD_0000) begin
      n_err++; $display("FAIL mread_data v_o=%b data=%h (want 01 dead0000)", v_o, data_o[0]);
    end
    yumi_i = 2'b01;
    @(negedge clk); yumi_i = 2'b00; #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    logic [1:0] g_hist [8];
    exp_g = 2'b10;  // port 0 won last
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); v_i = 2'b11; w_i = 2'b00; yumi_i = 2'b11;
      addr_i[0] = 10'd5; addr_i[1] = 10'd513; #1;
      g_hist[c] = exp_g;
      n_vec++;
      if (ready_o !== exp_g || sram_ce_o !== 1'b1) begin
        n_err++; $display("FAIL rr_grant c=%0d ready=%b ce=%b want %b 1", c, ready_o, sram_ce_o, exp_g);
      end
      if (c >= 2) begin
        n_vec++;
        if (v_o !== g_hist[c-2] || (v_o[0] && data_o[0] !== 32'hDEAD_0000) || (v_o[1] && data_o[1] !== 32'h0)) begin
          n_err++; $display("FAIL rr_resp c=%0d v_o=%b d0=%h d1=%h want v_o=%b", c, v_o, data_o[0], data_o[1], g_hist[c-2]);
        end
      end
      exp_g = ~exp_g;
    end
    @(negedge clk); v_i = 2'b00;
    @(negedge clk);
    @(negedge clk); yumi_i = 2'b00; #1;
  endtask

  task automatic test_hold();
    @(negedge clk); v_i = 2'b10; w_i = 2'b00; addr_i[1] = 10'd5; yumi_i = 2'b00; #1;
    n_vec++;
    if (ready_o !== 2'b10) begin
      n_err++; $display("FAIL hold_issue ready=%b want 10", ready_o);
    end
    @(negedge clk); v_i = 2'b00; yumi_i = 2'b10; #1;
    @(negedge clk); v_i = 2'b10; addr_i[1] = 10'd513; yumi_i = 2'b00; #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (ready_o !== 2'b00 || v_o[1] !== 1'b1 || data_o[1] !== 32'hDEAD_0000) begin
        n_err++; $display("FAIL hold_block k=%0d ready=%b v_o1=%b d1=%h (want 00 1 dead0000)", k, ready_o, v_o[1], data_o[1]);
      end
      @(negedge clk); #1;
    end
    yumi_i = 2'b10; #1;
    n_vec++;
    if (ready_o !== 2'b10 || v_o[1] !== 1'b1) begin
      n_err++; $display("FAIL hold_release ready=%b v_o1=%b want 10 1", ready_o, v_o[1]);
    end
    @(negedge clk); v_i = 2'b00; yumi_i = 2'b00; #1;
    n_vec++;
    if (v_o[1] !== 1'b0) begin
      n_err++; $display("FAIL hold_consumed v_o1=%b want 0", v_o[1]);
    end
    @(negedge clk); #1;
    n_vec++;
    if (v_o[1] !== 1'b1 || data_o[1] !== 32'h0) begin
      n_err++; $display("FAIL hold_new v_o1=%b d1=%h want 1 00000000", v_o[1], data_o[1]);
    end
    yumi_i = 2'b10;
    @(negedge clk); yumi_i = 2'b00; #1;
  endtask

  task automatic test_reset_restart();
    int n;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
    end
    n_vec++;
    if (sram_addr_o !== 10'd300) begin
      n_err++; $display("FAIL restart_pre addr=%0d want 300", sram_addr_o);
    end
    reset_i = 1'b1; #1;
    n_vec++;
    if (sram_ce_o !== 1'b0 || sram_we_o !== 1'b0 || sram_addr_o !== 10'd0 || sram_w_mask_o !== 32'h0) begin
      n_err++; $display("FAIL restart_sram ce=%b we=%b addr=%0d mask=%h want all 0", sram_ce_o, sram_we_o, sram_addr_o, sram_w_mask_o);
    end
    @(negedge clk); reset_i = 1'b0; #1;
    wait_init(n);
    n_vec++;
    if (n != 1024) begin
      n_err++; $display("FAIL restart_latency got %0d cycles want 1024", n);
    end
    @(negedge clk); v_i = 2'b01; w_i = 2'b00; addr_i[0] = 10'd7; #1;
    n_vec++;
    if (ready_o !== 2'b01) begin
      n_err++; $display("FAIL flush_issue ready=%b want 01", ready_o);
    end
    @(negedge clk); v_i = 2'b00; reset_i = 1'b1; #1;
    @(negedge clk); reset_i = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (v_o !== 2'b00) begin
        n_err++; $display("FAIL flush_v k=%0d v_o=%b want 00", k, v_o);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_random();
    int         n, win, last_g, cyc;
    bit         have [2];
    int         avail [2];
    logic [31:0] rsp_d [2];
    logic [1:0] vis, infl, elig, exp_ready;
    logic       exp_ce, exp_we;
    logic [9:0] exp_addr;
    logic [31:0] exp_wd, exp_mask;
    do_reset();
    wait_init(n);
    n_vec++;
    if (n != 1024) begin
      n_err++; $display("FAIL rand_init got %0d cycles want 1024", n);
    end
    for (int a = 0; a < 1024; a++) ref_mem[a] = 32'h0;
    have[0] = 0; have[1] = 0; avail[0] = 0; avail[1] = 0;
    rsp_d[0] = 32'h0; rsp_d[1] = 32'h0;
    last_g = 1; cyc = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      v_i = 2'($urandom); w_i = 2'($urandom); yumi_i = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        addr_i[p] = 10'($urandom_range(0, 15));
        data_i[p] = $urandom;
        mask_i[p] = $urandom;
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        vis[p]  = have[p] && (cyc >= avail[p]);
        infl[p] = have[p] && (cyc < avail[p]);
        elig[p] = v_i[p] && (w_i[p] || (!infl[p] && (!vis[p] || yumi_i[p])));
      end
      if (elig == 2'b11) win = 1 - last_g;
      else if (elig[0]) win = 0;
      else if (elig[1]) win = 1;
      else win = -1;
      exp_ready = 2'b00; exp_ce = 1'b0; exp_we = 1'b0;
      exp_addr = 10'd0; exp_wd = 32'h0; exp_mask = 32'h0;
      if (win >= 0) begin
        exp_ready[win] = 1'b1; exp_ce = 1'b1; exp_we = w_i[win];
        exp_addr = addr_i[win]; exp_wd = data_i[win]; exp_mask = mask_i[win];
      end
      n_vec++;
      if (ready_o !== exp_ready || sram_ce_o !== exp_ce || sram_we_o !== exp_we ||
          sram_addr_o !== exp_addr || sram_wd_o !== exp_wd || sram_w_mask_o !== exp_mask) begin
        n_err++;
        $display("FAIL rand_req t=%0d ready=%b ce=%b we=%b addr=%0d wd=%h mask=%h want %b %b %b %0d %h %h",
                 t, ready_o, sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o, sram_w_mask_o,
                 exp_ready, exp_ce, exp_we, exp_addr, exp_wd, exp_mask);
      end
      n_vec++;
      if (v_o !== vis || (vis[0] && data_o[0] !== rsp_d[0]) || (vis[1] && data_o[1] !== rsp_d[1])) begin
        n_err++;
        $display("FAIL rand_rsp t=%0d v_o=%b d0=%h d1=%h want %b %h %h", t, v_o, data_o[0], data_o[1], vis, rsp_d[0], rsp_d[1]);
      end
      for (int p = 0; p < 2; p++) begin
        if (vis[p] && yumi_i[p]) have[p] = 0;
      end
      if (win >= 0) begin
        if (w_i[win]) begin
          ref_mem[addr_i[win]] = (ref_mem[addr_i[win]] & ~mask_i[win]) | (data_i[win] & mask_i[win]);
        end else begin
          have[win] = 1; avail[win] = cyc + 2; rsp_d[win] = ref_mem[addr_i[win]];
        end
        last_g = win;
      end
      cyc++;
    end
    idle_inputs();
  endtask

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    for (int a = 0; a < 1024; a++) fake_mem[a] = $urandom;
    sram_rd_i = 32'h0;
    test_reset();
    test_init();
    test_masked_write();
    test_back_to_back();
    test_hold();
    test_reset_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_fakeram_1024x32_arb_ctrl.md
BSG_FAKERAM_1024X32_ARB_CTRL -- requirements
Module: bsg_fakeram_1024x32_arb_ctrl

Interface
REQ-001 Parameters SHALL be:
- els_p, 1024, words in SRAM.
- width_p, 32, data bits.
- addr_width_p, 10, address bits.
REQ-002 Ports SHALL be as follows (one clock; reset is synchronous and active-high):
- clk_i  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- init_done_o  out  1  SRAM zero-fill complete.
- v_i  in  [1:0]  per-port request valid.
- ready_o  out  [1:0]  per-port request accepted (grant).
- w_i  in  [1:0]  1 = write, 0 = read.
- addr_i  in  [1:0][addr_width_p-1:0]  word address.
- data_i  in  [1:0][width_p-1:0]  write data.
- mask_i  in  [1:0][width_p-1:0]  write bit mask; 1 = bit written.
- v_o  out  [1:0]  read response valid.
- data_o  out  [1:0][width_p-1:0]  read response data.
- yumi_i  in  [1:0]  response consumed.
- sram_ce_o  out  1  SRAM chip enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  addr_width_p  SRAM address.
- sram_wd_o  out  width_p  SRAM write data.
- sram_w_mask_o  out  width_p  SRAM write mask.
- sram_rd_i  in  width_p  SRAM read data, valid the cycle after a read.

Function
REQ-003 The block SHALL use a two-state FSM, INIT -> RUN; the INIT -> RUN transition SHALL occur after the write to address els_p-1.
REQ-004 In INIT, the block SHALL write 0 with an all-ones mask to addresses 0..els_p-1, one per cycle, using a counter; ready_o SHALL be 0 and init_done_o SHALL be 0.
REQ-005 In RUN, init_done_o SHALL be 1.
REQ-006 Port i SHALL be eligible when v_i[i]=1 and either:
- w_i[i]=1, or
- inflight[i]=0 and (v_o[i]=0 or yumi_i[i]=1).
REQ-007 Arbitration among eligible ports SHALL be 2-way round-robin: with both eligible, the port not granted last SHALL win; with one eligible, that port SHALL win.
REQ-008 ready_o SHALL be combinational from v_i, w_i, yumi_i and state; requesters SHALL NOT make v_i depend on ready_o.
REQ-009 A grant SHALL drive, in the same cycle:
- sram_ce_o=1;
- sram_we_o=w_i;
- the winning port's addr, data and mask onto the SRAM port.
REQ-010 With no grant in RUN, sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o and sram_w_mask_o SHALL be 0.
REQ-011 A read accepted in cycle t SHALL:
- set inflight[i] during cycle t+1;
- capture sram_rd_i into data_o[i] at the end of t+1;
- assert v_o[i] from t+2 until the cycle yumi_i[i]=1.
REQ-012 Read latency SHALL be exactly 2 cycles, from acceptance to v_o[i] rising.
REQ-013 Each port SHALL have at most one read outstanding (in flight or buffered).
REQ-014 data_o[i] SHALL hold stable while v_o[i]=1.
REQ-015 A read accepted in cycle t SHALL observe all writes accepted before t.
REQ-016 Writes SHALL produce no response.
REQ-017 yumi_i[i] asserted while v_o[i]=0 SHALL be ignored.
REQ-018 When yumi_i[i]=1 and a new response lands in the same cycle, v_o[i] SHALL remain 1 with the new data.

Reset
REQ-019 reset_i SHALL take effect at the next clk_i edge and SHALL force:
- state = INIT, init counter = 0;
- v_o = 0, inflight = 0, data_o = 0;
- round-robin last-grant = port 1 (port 0 wins first).
REQ-020 Reset asserted mid-INIT or mid-RUN SHALL restart the zero-fill from address 0 and discard in-flight reads.
REQ-021 During reset, all sram_* outputs SHALL be 0.

Structure
REQ-022 Package bsg_fakeram_arb_pkg SHALL hold the FSM state enum (INIT, RUN) and the default els/width/addr constants.
REQ-023 A single sub-module, bsg_arb_rr_2 (2-way round-robin arbiter with a last-grant register and a grant-advance strobe), SHALL implement REQ-007.

Verification
REQ-024 Reset, then idle -> init_done_o rises exactly 1024 cycles after reset deasserts; a port-0 read of address 513 then returns 0x00000000.
REQ-025 Port 0 writes 0xDEADBEEF to address 5 with mask 0xFFFF0000, then reads address 5 the next cycle -> data_o[0]=0xDEAD0000, with v_o[0] rising 2 cycles after the read is accepted.
REQ-026 Both ports present reads every cycle with yumi_i tied to 1 -> grants alternate 0,1,0,1; sram_ce_o=1 every cycle; each port gets one response per 2 cycles.
REQ-027 Port 1 read response held (yumi_i[1]=0) while port 1 issues another read -> ready_o[1]=0; port 1 is granted in the same cycle yumi_i[1]=1, and the new response appears 2 cycles later with the old data consumed.
REQ-028 Reset asserted at init counter 300, then released -> zero-fill restarts at address 0 and init_done_o rises 1024 cycles after the release; reset asserted with a read in flight -> v_o stays 0.
